// File: rtl/lsu_mem_pkg.sv
// Shared types for the LSU memory initiator.
// Default widths match the Cyclotron LSU channel.
package lsu_mem_pkg;

  localparam int DEF_ARCH_LEN  = 32;
  localparam int DEF_NUM_WARPS = 8;
  localparam int DEF_REG_BITS  = 8;
  localparam int DEF_LSU_LANES = 16;
  localparam int DEF_TAG_BITS  = 32;
  localparam int DEF_NUM_TAGS  = 8;

  localparam int DATA_WIDTH   = DEF_LSU_LANES * DEF_ARCH_LEN;
  localparam int WARP_BITS    = $clog2(DEF_NUM_WARPS);
  localparam int TAG_IDX_BITS = $clog2(DEF_NUM_TAGS);

  typedef struct packed {
    logic                    store;
    logic [WARP_BITS-1:0]    warp;
    logic [DEF_REG_BITS-1:0] rd;
  } pend_t;

  typedef struct packed {
    logic                     store;
    logic [DATA_WIDTH-1:0]    address;
    logic [DEF_TAG_BITS-1:0]  tag;
    logic [DATA_WIDTH-1:0]    data;
    logic [DEF_LSU_LANES-1:0] mask;
  } req_t;

  typedef struct packed {
    logic [WARP_BITS-1:0]     warp;
    logic [DEF_REG_BITS-1:0]  rd;
    logic [DATA_WIDTH-1:0]    data;
    logic [DEF_LSU_LANES-1:0] valids;
  } wb_t;

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Core-op, memory req/resp and writeback channels.
// master is the initiator side, slave the core/memory side.
interface lsu_mem_initiator_if
  import lsu_mem_pkg::*;
#(
  parameter int ARCH_LEN  = DEF_ARCH_LEN,
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int REG_BITS  = DEF_REG_BITS,
  parameter int LSU_LANES = DEF_LSU_LANES,
  parameter int TAG_BITS  = DEF_TAG_BITS,
  localparam int DW = LSU_LANES * ARCH_LEN,
  localparam int WB = $clog2(NUM_WARPS)
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_store;
  logic [WB-1:0]        in_warp;
  logic [REG_BITS-1:0]  in_rd;
  logic [DW-1:0]        in_address;
  logic [DW-1:0]        in_data;
  logic [LSU_LANES-1:0] in_mask;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_store;
  logic [DW-1:0]        req_address;
  logic [TAG_BITS-1:0]  req_tag;
  logic [DW-1:0]        req_data;
  logic [LSU_LANES-1:0] req_mask;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [TAG_BITS-1:0]  resp_tag;
  logic [DW-1:0]        resp_data;
  logic [LSU_LANES-1:0] resp_valids;

  logic                 wb_valid;
  logic                 wb_ready;
  logic [WB-1:0]        wb_warp;
  logic [REG_BITS-1:0]  wb_rd;
  logic [DW-1:0]        wb_data;
  logic [LSU_LANES-1:0] wb_valids;

  modport master (
    input  in_valid, in_store, in_warp, in_rd,
    input  in_address, in_data, in_mask,
    output in_ready,
    output req_valid, req_store, req_address,
    output req_tag, req_data, req_mask,
    input  req_ready,
    input  resp_valid, resp_tag, resp_data, resp_valids,
    output resp_ready,
    output wb_valid, wb_warp, wb_rd, wb_data, wb_valids,
    input  wb_ready
  );

  modport slave (
    output in_valid, in_store, in_warp, in_rd,
    output in_address, in_data, in_mask,
    input  in_ready,
    input  req_valid, req_store, req_address,
    input  req_tag, req_data, req_mask,
    output req_ready,
    output resp_valid, resp_tag, resp_data, resp_valids,
    input  resp_ready,
    input  wb_valid, wb_warp, wb_rd, wb_data, wb_valids,
    output wb_ready
  );
endinterface

// File: rtl/lsu_tag_pool.sv
// Transaction tag pool: free bitmask with a
// lowest-set-bit allocator and a single free port.
module lsu_tag_pool
  import lsu_mem_pkg::*;
#(
  parameter int N = DEF_NUM_TAGS,
  localparam int IW = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          alloc_i,
  input  logic          free_i,
  input  logic [IW-1:0] free_idx_i,
  output logic [IW-1:0] alloc_idx_o,
  output logic          empty_o,
  output logic [N-1:0]  mask_o
);
  logic [N-1:0] free_q, free_d;

  always_comb begin
    alloc_idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_q[i]) alloc_idx_o = IW'(i);
    end
  end

  // Alloc is taken from the pre-free mask.
  always_comb begin
    free_d = free_q;
    if (alloc_i) free_d[alloc_idx_o] = 1'b0;
    if (free_i)  free_d[free_idx_i]  = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) free_q <= '1;
    else       free_q <= free_d;
  end

  assign empty_o = ~|free_q;
  assign mask_o  = free_q;
endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU memory-channel initiator: tags ops, issues
// requests, matches responses, writes back loads.
module lsu_mem_initiator
  import lsu_mem_pkg::*;
#(
  parameter int ARCH_LEN  = DEF_ARCH_LEN,
  parameter int NUM_WARPS = DEF_NUM_WARPS,
  parameter int REG_BITS  = DEF_REG_BITS,
  parameter int LSU_LANES = DEF_LSU_LANES,
  parameter int TAG_BITS  = DEF_TAG_BITS,
  parameter int NUM_TAGS  = DEF_NUM_TAGS
) (
  input  logic clock,
  input  logic reset,
  lsu_mem_initiator_if.master bus,
  output logic idle,
  output logic tag_error
);
  localparam int DW  = LSU_LANES * ARCH_LEN;
  localparam int WB  = $clog2(NUM_WARPS);
  localparam int TIB = $clog2(NUM_TAGS);

  logic [TIB-1:0]      alloc_idx;
  logic [TIB-1:0]      resp_idx;
  logic [NUM_TAGS-1:0] free_mask;
  logic                pool_empty;
  logic                in_fire, resp_fire;
  logic                tag_ok, free_v;

  req_t  req_q, req_d;
  logic  req_valid_q, req_valid_d;
  wb_t   wb_q, wb_d;
  logic  wb_valid_q, wb_valid_d;
  logic  err_q, err_d;
  pend_t pend_q [NUM_TAGS];
  pend_t pend_r;

  assign bus.in_ready = !pool_empty &&
                        (!req_valid_q || bus.req_ready);
  assign in_fire = bus.in_valid && bus.in_ready;

  assign bus.resp_ready = !wb_valid_q || bus.wb_ready;
  assign resp_fire = bus.resp_valid && bus.resp_ready;
  assign resp_idx  = bus.resp_tag[TIB-1:0];
  assign pend_r    = pend_q[resp_idx];

  // Foreign or already-free tags are dropped.
  assign tag_ok = ((bus.resp_tag >> TIB) == '0) &&
                  !free_mask[resp_idx];
  assign free_v = resp_fire && tag_ok;

  lsu_tag_pool #(.N(NUM_TAGS)) u_pool (
    .clk_i       (clock),
    .rst_i       (reset),
    .alloc_i     (in_fire),
    .free_i      (free_v),
    .free_idx_i  (resp_idx),
    .alloc_idx_o (alloc_idx),
    .empty_o     (pool_empty),
    .mask_o      (free_mask)
  );

  always_comb begin
    req_valid_d = req_valid_q;
    req_d       = req_q;
    if (in_fire) begin
      req_valid_d = 1'b1;
      req_d = '{
        store:   bus.in_store,
        address: DW'(bus.in_address),
        tag:     TAG_BITS'(alloc_idx),
        data:    DW'(bus.in_data),
        mask:    LSU_LANES'(bus.in_mask)
      };
    end else if (bus.req_ready) begin
      req_valid_d = 1'b0;
    end
  end

  always_comb begin
    wb_valid_d = wb_valid_q;
    wb_d       = wb_q;
    if (bus.wb_ready) wb_valid_d = 1'b0;
    if (free_v && !pend_r.store) begin
      wb_valid_d = 1'b1;
      wb_d = '{
        warp:   pend_r.warp,
        rd:     pend_r.rd,
        data:   DW'(bus.resp_data),
        valids: LSU_LANES'(bus.resp_valids)
      };
    end
  end

  assign err_d = err_q | (resp_fire && !tag_ok);

  always_ff @(posedge clock) begin
    if (reset) begin
      req_valid_q <= 1'b0;
      req_q       <= '0;
      wb_valid_q  <= 1'b0;
      wb_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      req_valid_q <= req_valid_d;
      req_q       <= req_d;
      wb_valid_q  <= wb_valid_d;
      wb_q        <= wb_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) begin
      pend_q[alloc_idx] <= '{
        store: bus.in_store,
        warp:  WB'(bus.in_warp),
        rd:    REG_BITS'(bus.in_rd)
      };
    end
  end

  assign bus.req_valid   = req_valid_q;
  assign bus.req_store   = req_q.store;
  assign bus.req_address = req_q.address;
  assign bus.req_tag     = req_q.tag;
  assign bus.req_data    = req_q.data;
  assign bus.req_mask    = req_q.mask;

  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_warp   = wb_q.warp;
  assign bus.wb_rd     = wb_q.rd;
  assign bus.wb_data   = wb_q.data;
  assign bus.wb_valids = wb_q.valids;

  assign idle = (&free_mask) && !req_valid_q && !wb_valid_q;
  assign tag_error = err_q;
endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed bench for lsu_mem_initiator with a
// transaction-level reference model and per-cycle compare.
module tb_lsu_mem_initiator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic idle, tag_error;
  int   pass_cnt = 0;
  int   tot_cnt  = 0;

  always #5 clk = ~clk;

  lsu_mem_initiator_if bus();

  lsu_mem_initiator dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .idle      (idle),
    .tag_error (tag_error)
  );

  // reference model state
  logic [7:0]   m_free;
  bit           m_store [8];
  logic [2:0]   m_warp  [8];
  logic [7:0]   m_rd    [8];
  bit           m_req_v;
  logic         m_req_store;
  logic [511:0] m_req_addr, m_req_data;
  logic [31:0]  m_req_tag;
  logic [15:0]  m_req_mask;
  bit           m_wb_v;
  logic [2:0]   m_wb_warp;
  logic [7:0]   m_wb_rd;
  logic [511:0] m_wb_data;
  logic [15:0]  m_wb_valids;
  bit           m_err;

  function automatic bit m_in_ready();
    return (m_free != 8'h00) && (!m_req_v || bus.req_ready);
  endfunction

  function automatic bit m_resp_ready();
    return !m_wb_v || bus.wb_ready;
  endfunction

  function automatic bit m_idle();
    return (m_free == 8'hFF) && !m_req_v && !m_wb_v;
  endfunction

  task automatic check(input string nm,
                       input logic [511:0] act,
                       input logic [511:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_free      <= 8'hFF;
      m_req_v     <= 1'b0;
      m_req_store <= 1'b0;
      m_req_addr  <= '0;
      m_req_data  <= '0;
      m_req_tag   <= '0;
      m_req_mask  <= '0;
      m_wb_v      <= 1'b0;
      m_wb_warp   <= '0;
      m_wb_rd     <= '0;
      m_wb_data   <= '0;
      m_wb_valids <= '0;
      m_err       <= 1'b0;
    end else begin : upd
      bit         ig, rg;
      int         t, idx;
      logic [7:0] nf;
      nf = m_free;
      ig = bus.in_valid && m_in_ready();
      rg = bus.resp_valid && m_resp_ready();
      t = 0;
      for (int i = 0; i < 8; i++) begin
        if (m_free[i]) begin
          t = i;
          break;
        end
      end
      if (m_wb_v && bus.wb_ready) m_wb_v <= 1'b0;
      if (m_req_v && bus.req_ready) m_req_v <= 1'b0;
      if (rg) begin
        if (bus.resp_tag >= 32'd8 || m_free[bus.resp_tag[2:0]]) begin
          m_err <= 1'b1;
        end else begin
          idx = int'(bus.resp_tag);
          nf[idx] = 1'b1;
          if (!m_store[idx]) begin
            m_wb_v      <= 1'b1;
            m_wb_warp   <= m_warp[idx];
            m_wb_rd     <= m_rd[idx];
            m_wb_data   <= bus.resp_data;
            m_wb_valids <= bus.resp_valids;
          end
        end
      end
      if (ig) begin
        nf[t] = 1'b0;
        m_store[t]  <= bus.in_store;
        m_warp[t]   <= bus.in_warp;
        m_rd[t]     <= bus.in_rd;
        m_req_v     <= 1'b1;
        m_req_store <= bus.in_store;
        m_req_addr  <= bus.in_address;
        m_req_data  <= bus.in_data;
        m_req_tag   <= 32'(t);
        m_req_mask  <= bus.in_mask;
      end
      m_free <= nf;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", bus.in_ready, m_in_ready());
      check("req_valid", bus.req_valid, m_req_v);
      if (m_req_v) begin
        check("req_store", bus.req_store, m_req_store);
        check("req_tag", bus.req_tag, m_req_tag);
        check("req_address", bus.req_address, m_req_addr);
        check("req_data", bus.req_data, m_req_data);
        check("req_mask", bus.req_mask, m_req_mask);
      end
      check("resp_ready", bus.resp_ready, m_resp_ready());
      check("wb_valid", bus.wb_valid, m_wb_v);
      if (m_wb_v) begin
        check("wb_warp", bus.wb_warp, m_wb_warp);
        check("wb_rd", bus.wb_rd, m_wb_rd);
        check("wb_data", bus.wb_data, m_wb_data);
        check("wb_valids", bus.wb_valids, m_wb_valids);
      end
      check("idle", idle, m_idle());
      check("tag_error", tag_error, m_err);
    end
  end

  function automatic logic [511:0] lanes(input logic [31:0] base,
                                         input logic [31:0] step);
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = base + step * 32'(i);
    return v;
  endfunction

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit st, input int w, input int rd,
                       input logic [511:0] a, input logic [511:0] d,
                       input logic [15:0] m);
    int n;
    bit r;
    bus.in_valid   = 1'b1;
    bus.in_store   = st;
    bus.in_warp    = 3'(w);
    bus.in_rd      = 8'(rd);
    bus.in_address = a;
    bus.in_data    = d;
    bus.in_mask    = m;
    n = 0;
    do begin
      @(negedge clk);
      r = bus.in_ready;
      to_pos();
      n++;
    end while (!r && n < 50);
    bus.in_valid = 1'b0;
    if (!r) begin
      tot_cnt++;
      $display("FAIL issue_timeout: got in_ready=0 want 1");
    end
  endtask

  task automatic respond(input logic [31:0] tag,
                         input logic [511:0] d,
                         input logic [15:0] v);
    int n;
    bit r;
    bus.resp_valid  = 1'b1;
    bus.resp_tag    = tag;
    bus.resp_data   = d;
    bus.resp_valids = v;
    n = 0;
    do begin
      @(negedge clk);
      r = bus.resp_ready;
      to_pos();
      n++;
    end while (!r && n < 50);
    bus.resp_valid = 1'b0;
    if (!r) begin
      tot_cnt++;
      $display("FAIL resp_timeout: got resp_ready=0 want 1");
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] a5, da, db;
    bus.in_valid    = 1'b0;
    bus.in_store    = 1'b0;
    bus.in_warp     = '0;
    bus.in_rd       = '0;
    bus.in_address  = '0;
    bus.in_data     = '0;
    bus.in_mask     = '0;
    bus.req_ready   = 1'b1;
    bus.resp_valid  = 1'b0;
    bus.resp_tag    = '0;
    bus.resp_data   = '0;
    bus.resp_valids = '0;
    bus.wb_ready    = 1'b1;
    a5 = lanes(32'hA5, 32'h0);
    da = lanes(32'hDA00, 32'h1);
    db = lanes(32'hDB00, 32'h1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_req_valid", bus.req_valid, 1'b0);
    check("rst_resp_ready", bus.resp_ready, 1'b1);
    check("rst_wb_valid", bus.wb_valid, 1'b0);
    check("rst_idle", idle, 1'b1);
    check("rst_tag_error", tag_error, 1'b0);
    check("rst_req_tag", bus.req_tag, 32'h0);
    check("rst_wb_data", bus.wb_data, 512'h0);
    to_pos();

    // single load
    issue(0, 3, 5, lanes(32'h1000, 32'h4), '0, 16'hFFFF);
    @(negedge clk);
    check("ld_req_valid", bus.req_valid, 1'b1);
    check("ld_req_tag", bus.req_tag, 32'h0);
    check("ld_addr_lane0", bus.req_address[31:0], 32'h1000);
    to_pos();
    respond(32'h0, a5, 16'hFFFF);
    @(negedge clk);
    check("ld_wb_valid", bus.wb_valid, 1'b1);
    check("ld_wb_warp", bus.wb_warp, 3'd3);
    check("ld_wb_rd", bus.wb_rd, 8'd5);
    check("ld_wb_data", bus.wb_data, a5);
    to_pos();
    @(negedge clk);
    check("ld_idle", idle, 1'b1);
    to_pos();

    // pool exhaustion and tag reuse
    for (int i = 0; i < 8; i++)
      issue(0, i, 10 + i, lanes(32'h2000 + 32'(i), 32'h10),
            '0, 16'hFFFF);
    @(negedge clk);
    check("ex_last_tag", bus.req_tag, 32'd7);
    to_pos();
    bus.in_valid = 1'b1;
    bus.in_warp  = 3'd0;
    bus.in_rd    = 8'd99;
    bus.in_store = 1'b0;
    @(negedge clk);
    check("ex_stall", bus.in_ready, 1'b0);
    to_pos();
    respond(32'd2, da, 16'h0F0F);
    @(negedge clk);
    check("ex_reopen", bus.in_ready, 1'b1);
    to_pos();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("ex_reuse_tag", bus.req_tag, 32'd2);
    to_pos();
    respond(32'd0, db, 16'hFFFF);
    respond(32'd1, db, 16'hFFFF);
    for (int t = 3; t < 8; t++) respond(32'(t), da, 16'hFFFF);
    respond(32'd2, db, 16'hFFFF);
    repeat (2) @(negedge clk);
    check("ex_idle", idle, 1'b1);
    to_pos();

    // out-of-order responses
    issue(0, 1, 21, lanes(32'h3000, 32'h4), '0, 16'hFFFF);
    issue(0, 2, 22, lanes(32'h3100, 32'h4), '0, 16'hFFFF);
    issue(0, 3, 23, lanes(32'h3200, 32'h4), '0, 16'hFFFF);
    respond(32'd2, da, 16'hFFFF);
    @(negedge clk);
    check("ooo2_warp", bus.wb_warp, 3'd3);
    check("ooo2_rd", bus.wb_rd, 8'd23);
    to_pos();
    respond(32'd0, db, 16'hFFFF);
    @(negedge clk);
    check("ooo0_warp", bus.wb_warp, 3'd1);
    check("ooo0_rd", bus.wb_rd, 8'd21);
    to_pos();
    respond(32'd1, a5, 16'h00FF);
    @(negedge clk);
    check("ooo1_warp", bus.wb_warp, 3'd2);
    check("ooo1_rd", bus.wb_rd, 8'd22);
    to_pos();

    // store retires silently
    issue(1, 6, 7, lanes(32'h4000, 32'h4), db, 16'h00FF);
    @(negedge clk);
    check("st_req_store", bus.req_store, 1'b1);
    check("st_req_mask", bus.req_mask, 16'h00FF);
    check("st_req_data", bus.req_data, db);
    to_pos();
    respond(32'd0, a5, 16'hFFFF);
    @(negedge clk);
    check("st_no_wb", bus.wb_valid, 1'b0);
    check("st_idle", idle, 1'b1);
    to_pos();

    // writeback backpressure
    bus.wb_ready = 1'b0;
    issue(0, 4, 30, lanes(32'h5000, 32'h4), '0, 16'hFFFF);
    issue(0, 5, 31, lanes(32'h5100, 32'h4), '0, 16'hFFFF);
    respond(32'd0, da, 16'hFFFF);
    @(negedge clk);
    check("bp_resp_ready", bus.resp_ready, 1'b0);
    check("bp_first_rd", bus.wb_rd, 8'd30);
    to_pos();
    fork
      respond(32'd1, db, 16'h3333);
      begin
        repeat (3) @(negedge clk);
        check("bp_hold_data", bus.wb_data, da);
        check("bp_hold_rd", bus.wb_rd, 8'd30);
        to_pos();
        bus.wb_ready = 1'b1;
      end
    join
    @(negedge clk);
    check("bp_second_rd", bus.wb_rd, 8'd31);
    check("bp_second_data", bus.wb_data, db);
    to_pos();

    // bad tags
    respond(32'h100, a5, 16'hFFFF);
    @(negedge clk);
    check("bad_hi_err", tag_error, 1'b1);
    check("bad_hi_no_wb", bus.wb_valid, 1'b0);
    to_pos();
    respond(32'd4, a5, 16'hFFFF);
    @(negedge clk);
    check("bad_free_err", tag_error, 1'b1);
    check("bad_free_idle", idle, 1'b1);
    check("bad_free_no_wb", bus.wb_valid, 1'b0);
    to_pos();

    // reset mid-operation
    issue(0, 2, 40, lanes(32'h6000, 32'h4), '0, 16'hFFFF);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_err", tag_error, 1'b0);
    check("mid_rst_idle", idle, 1'b1);
    check("mid_rst_req_valid", bus.req_valid, 1'b0);
    to_pos();
    respond(32'd0, a5, 16'hFFFF);
    @(negedge clk);
    check("stale_tag_err", tag_error, 1'b1);
    check("stale_no_wb", bus.wb_valid, 1'b0);
    to_pos();

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
